// File: rtl/mem_access.sv
// Memory-stage data-access controller: issues SRAM-like bus transactions for
// loads/stores, stalls the pipeline until they finish, and registers results for WB.
module mem_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_ex_out,
  input  logic [31:0] in_wdata,
  input  logic        in_flush,
  output logic        m_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        w_valid,
  output logic [31:0] w_ex_out,
  output logic [31:0] w_rdata,
  output logic        w_adel,
  output logic        w_ades
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_e;

  state_e      state_q, state_d;
  logic        aligned;
  logic        is_mem;
  logic        access;
  logic        load_done;

  logic        w_valid_q, w_valid_d;
  logic [31:0] w_ex_out_q, w_ex_out_d;
  logic [31:0] w_rdata_q, w_rdata_d;
  logic        w_adel_q, w_adel_d;
  logic        w_ades_q, w_ades_d;

  // Alignment check, store-lane steering and byte enables; size 3 behaves as word.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    aligned    = 1'b1;
    data_wdata = in_wdata;
    data_wstrb = 4'b1111;
    case (in_size)
      2'd0: begin
        aligned    = 1'b1;
        data_wdata = {4{in_wdata[7:0]}};
        data_wstrb = 4'b0001 << in_ex_out[1:0];
      end
      2'd1: begin
        aligned    = ~in_ex_out[0];
        data_wdata = {2{in_wdata[15:0]}};
        data_wstrb = 4'b0011 << in_ex_out[1:0];
      end
      default: begin
        aligned    = (in_ex_out[1:0] == 2'b00);
        data_wdata = in_wdata;
        data_wstrb = 4'b1111;
      end
    endcase
  end

  assign is_mem    = in_memread | in_memwrite;
  assign access    = in_valid & is_mem & aligned & ~in_flush;
  assign data_wr   = in_memwrite;
  assign data_size = in_size;
  assign data_addr = in_ex_out;

  // Bus handshake FSM; stall logic lives here too since it depends on the state.
  always_comb begin
    state_d  = state_q;
    data_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_req = access;
        if (access) state_d = data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        // A flush can only withdraw a request the slave has not yet taken.
        if (in_flush && !data_addr_ok) begin
          data_req = 1'b0;
          state_d  = S_IDLE;
        end else begin
          data_req = 1'b1;
          if (data_addr_ok) state_d = in_flush ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok)  state_d = S_IDLE;
        else if (in_flush) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    m_stall = (access & ~((state_q == S_WAIT) & data_data_ok)) | (state_q == S_DISCARD);
  end

  assign load_done = (state_q == S_WAIT) & data_data_ok & access & in_memread;

  always_comb begin
    w_valid_d  = 1'b0;
    w_ex_out_d = w_ex_out_q;
    w_rdata_d  = w_rdata_q;
    w_adel_d   = w_adel_q;
    w_ades_d   = w_ades_q;
    if (!m_stall) begin
      w_valid_d  = in_valid & ~in_flush;
      w_ex_out_d = in_ex_out;
      w_adel_d   = in_valid & in_memread & ~aligned;
      w_ades_d   = in_valid & in_memwrite & ~aligned;
      if (load_done) w_rdata_d = data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    if (!resetn) begin
      state_q    <= S_IDLE;
      w_valid_q  <= 1'b0;
      w_ex_out_q <= 32'h0;
      w_rdata_q  <= 32'h0;
      w_adel_q   <= 1'b0;
      w_ades_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_valid_q  <= w_valid_d;
      w_ex_out_q <= w_ex_out_d;
      w_rdata_q  <= w_rdata_d;
      w_adel_q   <= w_adel_d;
      w_ades_q   <= w_ades_d;
    end
  end

  assign w_valid  = w_valid_q;
  assign w_ex_out = w_ex_out_q;
  assign w_rdata  = w_rdata_q;
  assign w_adel   = w_adel_q;
  assign w_ades   = w_ades_q;

endmodule
